prog_clk_divider: RTL and testbench
===================================

Name: prog_clk_divider

Overview:
- Runtime-programmable integer clock divider for the DPLL clock path.
- Divides clk_in by N (2..2^CNT_W-1), supporting both even and odd N.
- Takes ratio updates through a load/ack handshake; updates apply glitch-free at period boundaries.
- Accepts single-cycle phase-slip requests (period +/-1 input cycle) from the DPLL loop filter, and emits a one-cycle tick aligned to each rising edge of clk_o.

Parameters:
- CNT_W, 16: width of the ratio and of the period counter.
- DIV_DEFAULT, 5: ratio active after reset; must satisfy 2 <= DIV_DEFAULT <= 2^CNT_W-1.

Ports:
- clk_in  input  1  input clock; all logic on the rising edge, except the negedge stage of the optional feature.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  divider run enable.
- div_val  input  CNT_W  requested ratio N.
- div_load  input  1  single-cycle request to load div_val.
- div_ack  output  1  one-cycle pulse when the requested ratio becomes active.
- busy  output  1  a loaded ratio is pending.
- cfg_err  output  1  one-cycle pulse when div_val<2 is rejected.
- slip_add  input  1  lengthen a period by one clk_in cycle.
- slip_sub  input  1  shorten a period by one clk_in cycle.
- clk_o  output  1  divided clock.
- tick  output  1  one-cycle strobe, high in the clk_in cycle in which clk_o rises.
- div_cur  output  CNT_W  currently active ratio.

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, div_cur=DIV_DEFAULT, pending empty.
  - clk_o=0, tick=0, div_ack=0, busy=0, cfg_err=0.
  - Slip flags cleared.
- Counter:
  - cnt runs 0..L-1 and wraps to 0, where L is the period length (N, or N+/-1 when a slip applies).
  - A period starts at cnt=0.
- Output:
  - clk_o is registered and high while cnt < H, H = ceil(N/2); low for the rest of the period.
  - Even N gives exact 50% duty.
  - Odd N, without the macro: high N/2+0.5 cycles, low N/2-0.5 cycles.
- tick: registered; asserted in the same cycle that clk_o goes 0->1.
- en:
  - en=0: cnt forced to 0, clk_o=0, tick=0. Pending and slip state are held.
  - 0->1: clk_o rises on the first clk_in edge that samples en=1, with tick=1 in that cycle.
  - en dropping mid-period truncates that period immediately; no glitch shorter than one clk_in cycle.
- Load handshake:
  - div_load=1 with div_val>=2 captures div_val into pending and sets busy=1 from the next cycle.
  - The pending ratio is applied on the wrap cycle (cnt=L-1 -> 0): div_cur updates, div_ack pulses 1 cycle, busy clears.
  - The first period using the new N begins immediately after.
  - With en=0, the pending ratio is applied on the next cycle instead.
  - Load while busy: pending is overwritten (last wins); a single ack is issued.
  - Load coincident with a wrap: the captured value waits for the following wrap.
  - div_val<2: request ignored, cfg_err pulses 1 cycle, pending unchanged.
- Slip:
  - slip_add / slip_sub each set a one-deep flag.
  - A repeated request of the same sign while that flag is set is dropped.
  - Opposite flags cancel; add and sub in the same cycle are a no-op.
  - Flags are consumed at the wrap decision of the current period:
    - add: the period is extended by one extra low cycle (L=N+1).
    - sub: the period wraps at cnt=N-2 (L=N-1).
  - The sub flag is ignored (held) when N=2.
  - A request arriving in the wrap cycle itself applies to the next period.
  - Slips never alter the high phase.
  - Slip and ratio update on the same wrap: the slip applies to the old period, and the new N starts clean.
- Width: all comparisons are unsigned CNT_W-bit; L=N+1 with N=2^CNT_W-1 requires one extra counter bit internally.

Optional Feature:
- Macro: PROG_CLK_DIVIDER_DUTY50_EN.
- Defined: odd N gets exact 50% duty.
  - The posedge phase p is high for cnt < (N-1)/2.
  - A negedge flop n resamples p.
  - clk_o = p | n, glitch-free because the two overlap, giving high time N/2 cycles.
  - tick is unchanged.
  - Even N still uses the registered output.
- Undefined: no negedge logic; odd duty as in Behaviour.

Decomposition:
- Package prog_clk_div_pkg:
  - DIV_MIN=2.
  - Function ceil_half(N).
  - Enum slip_e {SLIP_NONE, SLIP_ADD, SLIP_SUB}.
- One natural sub-module: prog_clk_div_cfg, which holds the pending ratio and produces busy/div_ack/cfg_err and the apply strobe. The counter, slip and output logic stay in the top.

Test Plan:
- Reset, then en=1 with DIV_DEFAULT=5, no macro -> clk_o period 5 cycles, high 3 / low 2, one tick per period.
- Load div_val=8 mid-period -> busy=1 until the wrap; div_ack 1 cycle at the wrap; the next period is 8 cycles, 4/4; div_cur=8.
- N=6, slip_add pulse at cnt=2 -> that period is 7 cycles (high 3, low 4), the following one 6. slip_sub at cnt=5 (the wrap cycle) -> the next period is 5 cycles.
- div_val=1 load -> cfg_err pulse, div_cur unchanged, no ack. N=2 with slip_sub -> period stays 2.
- Macro defined, N=7 -> clk_o high exactly 3.5 clk_in cycles per 7; measured duty 50%.
- rst_n asserted mid-period with pending load and slip flag set -> all outputs 0 immediately; after release, ratio=DIV_DEFAULT and no stale ack or slip.

Source files
------------

// File: rtl/prog_clk_div_pkg.sv
// prog_clk_divider shared types and helpers.
// Ratio limits, slip flag encoding, half-period math.
package prog_clk_div_pkg;

    localparam int DIV_MIN = 2;

    typedef enum logic [1:0] {
        SLIP_NONE,
        SLIP_ADD,
        SLIP_SUB
    } slip_e;

    function automatic logic [31:0] ceil_half(
        input logic [31:0] n
    );
        return (n >> 1) + {31'd0, n[0]};
    endfunction

endpackage

// File: rtl/prog_clk_div_cfg.sv
// prog_clk_divider ratio config: pending ratio,
// load/ack handshake, reject of ratios below DIV_MIN.
module prog_clk_div_cfg
    import prog_clk_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_wrap,
    input  logic [CNT_W-1:0] i_val,
    input  logic             i_load,
    output logic             o_busy,
    output logic             o_ack,
    output logic             o_err,
    output logic             o_apply,
    output logic [CNT_W-1:0] o_div
);

    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] r_div;
    logic             r_busy;
    logic             r_ack;
    logic             r_err;
    logic             w_ok;
    logic             w_bad;

    assign w_ok    = i_load & (i_val >= CNT_W'(DIV_MIN));
    assign w_bad   = i_load & (i_val <  CNT_W'(DIV_MIN));
    // A stopped divider has no boundary to wait for.
    assign o_apply = r_busy & (i_wrap | ~i_en);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= CNT_W'(DIV_DEFAULT);
            r_div  <= CNT_W'(DIV_DEFAULT);
            r_busy <= 1'b0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_ack  <= o_apply;
            r_err  <= w_bad;
            r_busy <= w_ok | (r_busy & ~o_apply);
            if (o_apply)
                r_div <= r_pend;
            if (w_ok)
                r_pend <= i_val;
        end
    end

    assign o_busy = r_busy;
    assign o_ack  = r_ack;
    assign o_err  = r_err;
    assign o_div  = r_div;

endmodule

// File: rtl/prog_clk_divider.sv
// Programmable integer clock divider with phase slip.
// PROG_CLK_DIVIDER_DUTY50_EN adds exact 50% duty for odd N.
module prog_clk_divider
    import prog_clk_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             busy,
    output logic             cfg_err,
    input  logic             slip_add,
    input  logic             slip_sub,
    output logic             clk_o,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur
);

    localparam logic [CNT_W:0] ONE = 1;
    localparam logic [CNT_W:0] TWO = 2;

    logic [CNT_W:0] r_cnt;
    logic [CNT_W:0] w_div;
    logic [CNT_W:0] w_last;
    logic [CNT_W:0] w_phi;
    slip_e          r_slip;
    slip_e          w_base;
    slip_e          w_slip_nx;
    logic           w_sub_ok;
    logic           w_wrap;
    logic           w_apply;
    logic           w_p;
    logic           r_clk;
    logic           r_tick;

    prog_clk_div_cfg #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_cfg (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .i_en    (en),
        .i_wrap  (w_wrap),
        .i_val   (div_val),
        .i_load  (div_load),
        .o_busy  (busy),
        .o_ack   (div_ack),
        .o_err   (cfg_err),
        .o_apply (w_apply),
        .o_div   (div_cur)
    );

    // One extra bit so N+1 fits for the largest N.
    assign w_div    = {1'b0, div_cur};
    assign w_sub_ok = (div_cur != CNT_W'(DIV_MIN));

    always_comb begin
        w_last = w_div - ONE;
        unique case (r_slip)
            SLIP_ADD: w_last = w_div;
            SLIP_SUB: w_last = w_sub_ok ? w_div - TWO : w_div - ONE;
            default:  w_last = w_div - ONE;
        endcase
    end

    assign w_wrap = en & (r_cnt >= w_last);

    always_comb begin
        w_base = r_slip;
        if (w_wrap)
            w_base = (r_slip == SLIP_SUB && !w_sub_ok && !w_apply)
                   ? SLIP_SUB : SLIP_NONE;
        w_slip_nx = w_base;
        if (en) begin
            unique case ({slip_add, slip_sub})
                2'b10:   w_slip_nx = (w_base == SLIP_SUB) ? SLIP_NONE : SLIP_ADD;
                2'b01:   w_slip_nx = (w_base == SLIP_ADD) ? SLIP_NONE : SLIP_SUB;
                default: w_slip_nx = w_base;
            endcase
        end
    end

`ifdef PROG_CLK_DIVIDER_DUTY50_EN
    assign w_phi = div_cur[0] ? (w_div >> 1)
                 : (CNT_W+1)'(ceil_half(32'(div_cur)));
`else
    assign w_phi = (CNT_W+1)'(ceil_half(32'(div_cur)));
`endif

    assign w_p = en & (r_cnt < w_phi);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_slip <= SLIP_NONE;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_wrap || !en ? '0 : r_cnt + ONE;
            r_slip <= w_slip_nx;
            r_clk  <= w_p;
            r_tick <= w_p & ~r_clk;
        end
    end

`ifdef PROG_CLK_DIVIDER_DUTY50_EN
    logic r_odd;
    logic r_neg;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            r_odd <= 1'b0;
        else
            r_odd <= div_cur[0];
    end

    // Half-cycle stretch; overlaps r_clk so the OR cannot glitch.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n)
            r_neg <= 1'b0;
        else
            r_neg <= r_clk & r_odd;
    end

    assign clk_o = r_clk | r_neg;
`else
    assign clk_o = r_clk;
`endif

    assign tick = r_tick;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider against a
// period-level reference model; random and directed phases.
module tb_prog_clk_divider;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] div_val;
    logic        div_load;
    logic        div_ack;
    logic        busy;
    logic        cfg_err;
    logic        slip_add;
    logic        slip_sub;
    logic        clk_o;
    logic        tick;
    logic [15:0] div_cur;

    int n_tests = 0;
    int n_fail  = 0;

    int m_pos, m_N, m_pend, m_slip;
    bit m_busy, m_clk, m_tick, m_ack, m_err, m_odd;

    int cur_len, cur_hi, cur_halves;
    int last_len, last_hi, last_halves;

    always #5 clk_in = ~clk_in;

    prog_clk_divider #(
        .CNT_W       (16),
        .DIV_DEFAULT (5)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_ack  (div_ack),
        .busy     (busy),
        .cfg_err  (cfg_err),
        .slip_add (slip_add),
        .slip_sub (slip_sub),
        .clk_o    (clk_o),
        .tick     (tick),
        .div_cur  (div_cur)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_N = 5; m_pend = 5; m_slip = 0;
        m_busy = 0; m_clk = 0; m_tick = 0;
        m_ack = 0; m_err = 0; m_odd = 0;
        cur_len = 0; cur_hi = 0; cur_halves = 0;
        last_len = 0; last_hi = 0; last_halves = 0;
    endtask

    // Period length is N, N+1 on a pending add, N-1 on a
    // pending sub (sub ignored for N=2).
    task automatic model_step(input bit e, input bit ld,
                              input int v, input bit sa,
                              input bit ss);
        int len, d, s;
        bit wrap, apply, c;
        len = m_N + ((m_slip == 1) ? 1
              : ((m_slip == -1 && m_N > 2) ? -1 : 0));
        wrap  = e && (m_pos >= len - 1);
        apply = m_busy && (wrap || !e);
        c = e && (m_pos < (m_N + 1) / 2);
        m_tick = c && !m_clk;
        m_clk  = c;
        m_odd  = (m_N % 2) == 1;
        s = m_slip;
        if (wrap)
            s = (m_slip == -1 && m_N == 2 && !apply) ? -1 : 0;
        d = int'(sa) - int'(ss);
        if (e && d != 0)
            s = (s == -d) ? 0 : d;
        m_slip = s;
        m_ack = apply;
        m_err = ld && v < 2;
        if (apply) begin
            m_N = m_pend;
            m_busy = 0;
        end
        if (ld && v >= 2) begin
            m_pend = v;
            m_busy = 1;
        end
        m_pos = (!e || wrap) ? 0 : m_pos + 1;
    endtask

    task automatic step(input bit e, input bit ld,
                        input int v, input bit sa,
                        input bit ss);
        @(negedge clk_in);
        #1;
        cur_halves += int'(clk_o);
        en = e; div_load = ld; div_val = 16'(v);
        slip_add = sa; slip_sub = ss;
        @(posedge clk_in);
        model_step(e, ld, v, sa, ss);
        #1;
`ifdef PROG_CLK_DIVIDER_DUTY50_EN
        if (!m_odd)
            check("clk_o", clk_o, m_clk);
`else
        check("clk_o", clk_o, m_clk);
`endif
        check("tick", tick, m_tick);
        check("div_ack", div_ack, m_ack);
        check("busy", busy, m_busy);
        check("cfg_err", cfg_err, m_err);
        check("div_cur", div_cur, m_N);
        if (tick) begin
            last_len = cur_len; last_hi = cur_hi;
            last_halves = cur_halves;
            cur_len = 1; cur_hi = 1; cur_halves = 1;
        end else begin
            cur_len++;
            cur_hi += int'(clk_o);
            cur_halves += int'(clk_o);
        end
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0);
    endtask

    task automatic run_ticks(input int k);
        int seen = 0;
        int guard = 0;
        while (seen < k && guard < 300) begin
            idle();
            if (tick) seen++;
            guard++;
        end
        if (seen < k)
            check("tick_timeout", seen, k);
    endtask

    task automatic run_to(input int pos);
        int guard = 0;
        while (m_pos != pos && guard < 300) begin
            idle();
            guard++;
        end
        if (m_pos != pos)
            check("pos_timeout", m_pos, pos);
    endtask

    task automatic load_wait(input int v);
        step(1, 1, v, 0, 0);
        run_ticks(2);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_clk"}, clk_o, 0);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_ack"}, div_ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, cfg_err, 0);
        check({tag, "_div"}, div_cur, 5);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; div_val = '0;
        div_load = 1'b0; slip_add = 1'b0; slip_sub = 1'b0;
        model_reset();
        #21;
        check_reset_outs("rst");
        rst_n = 1'b1;

        // Default ratio 5: 3 high / 2 low.
        run_ticks(3);
        check("n5_len", last_len, 5);
        check("n5_hi", last_hi, 3);

        // Mid-period load of 8.
        run_to(2);
        step(1, 1, 8, 0, 0);
        check("n8_busy", busy, 1);
        run_ticks(3);
        check("n8_len", last_len, 8);
        check("n8_hi", last_hi, 4);
        check("n8_cur", div_cur, 8);

        // N=6 with add at cnt=2, then sub in the wrap cycle.
        load_wait(6);
        run_ticks(1);
        run_to(2);
        step(1, 0, 0, 1, 0);
        run_ticks(1);
        check("add_len", last_len, 7);
        check("add_hi", last_hi, 3);
        run_ticks(1);
        check("post_add_len", last_len, 6);
        run_to(5);
        step(1, 0, 0, 0, 1);
        run_ticks(1);
        check("sub_pre_len", last_len, 6);
        run_ticks(1);
        check("sub_len", last_len, 5);

        // Rejected ratio.
        step(1, 1, 1, 0, 0);
        check("err_pulse", cfg_err, 1);
        check("err_cur", div_cur, 6);
        idle();
        check("err_noack", div_ack, 0);

        // N=2 ignores sub.
        load_wait(2);
        step(1, 0, 0, 0, 1);
        run_ticks(3);
        check("n2_len", last_len, 2);

        // Odd-ratio duty measured in half cycles.
        load_wait(7);
        run_ticks(2);
        check("n7_len", last_len, 7);
`ifdef PROG_CLK_DIVIDER_DUTY50_EN
        check("n7_halves", last_halves, 7);
`else
        check("n7_halves", last_halves, 8);
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit e, ld, sa, ss;
            int v;
            e  = ($urandom_range(0, 15) != 0);
            ld = ($urandom_range(0, 19) == 0);
            v  = $urandom_range(0, 12);
            sa = ($urandom_range(0, 9) == 0);
            ss = ($urandom_range(0, 9) == 0);
            step(e, ld, v, sa, ss);
        end

        // Async reset with a pending load and slip flag.
        step(1, 1, 9, 1, 0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("arst");
        model_reset();
        rst_n = 1'b1;
        run_ticks(3);
        check("arst_len", last_len, 5);
        check("arst_cur", div_cur, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
